cache_datapath_nway: RTL

- Parametrised N-way set-associative cache datapath: data, tag, valid, dirty and tree-PLRU storage, plus hit detection, victim selection and a set-clear walker.
- Successor to the fixed 2-way datapath: generalised in ways, sets and line size.
- Adds registered lookup responses, byte-masked line writes, automatic PLRU update on hit, and flush/init sequencing.
- Sits between the cache controller FSM and the CPU/memory line buses.

---
 rtl/cache_datapath_nway_pkg.sv | 26 ++
 rtl/cache_datapath_nway_plru.sv | 49 ++++
 rtl/cache_datapath_nway.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/cache_datapath_nway_pkg.sv
// Shared definitions for the N-way cache datapath: default geometry,
// derived widths, walker state encoding and convenience typedefs.
package cache_pkg;

    // Default geometry; modules re-derive their own widths from parameters.
    localparam int DEF_S_OFFSET = 5;
    localparam int DEF_S_INDEX  = 3;
    localparam int DEF_NUM_WAYS = 4;
    localparam int DEF_ADDR_W   = 32;

    localparam int S_TAG    = DEF_ADDR_W - DEF_S_INDEX - DEF_S_OFFSET;
    localparam int S_MASK   = 2 ** DEF_S_OFFSET;
    localparam int S_LINE   = 8 * S_MASK;
    localparam int WAY_W    = $clog2(DEF_NUM_WAYS);
    localparam int NUM_SETS = 2 ** DEF_S_INDEX;

    // Set-clear walker: WALK is also the state entered from reset.
    typedef enum logic {
        ST_IDLE,
        ST_WALK
    } walk_state_t;

    typedef logic [WAY_W-1:0]  way_t;
    typedef logic [S_LINE-1:0] line_t;

endpackage

// File: rtl/cache_datapath_nway_plru.sv
// Tree pseudo-LRU helper for one set: derives the victim way from the
// node bits and computes the node bits after touching a way.
// Node n has children 2n+1 (left, lower ways) and 2n+2 (right).
// A node bit of 1 means the victim lies in the right subtree.
module cache_plru #(
    parameter int NUM_WAYS = 4
) (
    input  logic [NUM_WAYS-2:0]         tree,
    input  logic [$clog2(NUM_WAYS)-1:0] touch_way,
    output logic [$clog2(NUM_WAYS)-1:0] victim,
    output logic [NUM_WAYS-2:0]         next_tree
);

    localparam int WAYS_W = $clog2(NUM_WAYS);
    localparam int TREE_W = NUM_WAYS - 1;

    // Follow node bits from the root to the victim leaf, MSB of the way first.
    always_comb begin
        int unsigned node;
        node   = 0;
        victim = '0;
        for (int unsigned lvl = 0; lvl < WAYS_W; lvl++) begin
            if (((tree >> node) & TREE_W'(1)) != '0) begin
                victim = (victim << 1) | WAYS_W'(1);
                node   = 2 * node + 2;
            end else begin
                victim = victim << 1;
                node   = 2 * node + 1;
            end
        end
    end

    // Point every node on the touched way's path away from it.
    always_comb begin
        int unsigned node;
        node      = 0;
        next_tree = tree;
        for (int unsigned lvl = 0; lvl < WAYS_W; lvl++) begin
            if (((touch_way >> (WAYS_W - 1 - lvl)) & WAYS_W'(1)) != '0) begin
                next_tree = next_tree & ~(TREE_W'(1) << node);
                node      = 2 * node + 2;
            end else begin
                next_tree = next_tree | (TREE_W'(1) << node);
                node      = 2 * node + 1;
            end
        end
    end

endmodule

// File: rtl/cache_datapath_nway.sv
// N-way set-associative cache datapath: line/tag/valid/dirty/PLRU storage,
// registered lookup with hit and victim reporting, byte-masked line writes,
// and a walker that clears one set per cycle after reset or on flush.
module cache_datapath_nway
    import cache_pkg::*;
#(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 3,
    parameter int NUM_WAYS = 4,
    parameter int ADDR_W   = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 req_valid,
    input  logic [ADDR_W-1:0]                    req_addr,
    output logic                                 rsp_valid,
    output logic                                 rsp_hit,
    output logic [$clog2(NUM_WAYS)-1:0]          rsp_way,
    output logic [8*(2**S_OFFSET)-1:0]           rsp_line,
    output logic                                 rsp_victim_valid,
    output logic                                 rsp_victim_dirty,
    output logic [ADDR_W-S_INDEX-S_OFFSET-1:0]   rsp_victim_tag,
    input  logic                                 wr_en,
    input  logic [ADDR_W-1:0]                    wr_addr,
    input  logic [$clog2(NUM_WAYS)-1:0]          wr_way,
    input  logic [8*(2**S_OFFSET)-1:0]           wr_line,
    input  logic [(2**S_OFFSET)-1:0]             wr_byte_en,
    input  logic                                 wr_tag_en,
    input  logic                                 wr_dirty_set,
    input  logic                                 wr_dirty_clr,
    input  logic                                 wr_touch,
    input  logic                                 flush_req,
    output logic                                 busy
);

    localparam int TAG_W  = ADDR_W - S_INDEX - S_OFFSET;
    localparam int MASK_W = 2 ** S_OFFSET;
    localparam int LINE_W = 8 * MASK_W;
    localparam int WAYS_W = $clog2(NUM_WAYS);
    localparam int SETS   = 2 ** S_INDEX;
    localparam int TREE_W = NUM_WAYS - 1;

    localparam logic [S_INDEX:0] LAST_SET = (S_INDEX + 1)'(SETS - 1);
    localparam logic [S_INDEX:0] CNT_ONE  = (S_INDEX + 1)'(1);

    // Storage: data/tag are never reset; valid/dirty/PLRU are cleared by the walker.
    logic [LINE_W-1:0]   data_mem  [SETS][NUM_WAYS];
    logic [TAG_W-1:0]    tag_mem   [SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_mem [SETS];
    logic [NUM_WAYS-1:0] dirty_mem [SETS];
    logic [TREE_W-1:0]   plru_mem  [SETS];

    walk_state_t      state, state_nx;
    logic [S_INDEX:0] walk_cnt, walk_cnt_nx;
    logic [S_INDEX-1:0] walk_set;

    logic [TAG_W-1:0]   req_tag, wr_tag;
    logic [S_INDEX-1:0] req_set, wr_set;
    logic               req_go, wr_go;

    logic [NUM_WAYS-1:0] hit_vec, inv_vec;
    logic                lk_hit;
    logic [WAYS_W-1:0]   hit_way, plru_victim, victim_way, lk_way;
    logic [TREE_W-1:0]   lk_tree, hit_tree, wr_base_tree, wr_tree;
    logic [LINE_W-1:0]   wr_old, wr_merged;
    logic [WAYS_W-1:0]   unused_wr_victim;
    logic                unused_offset_bits;

    function automatic logic [WAYS_W-1:0] first_set(input logic [NUM_WAYS-1:0] vec);
        logic found;
        found     = 1'b0;
        first_set = '0;
        for (int unsigned i = 0; i < NUM_WAYS; i++) begin
            if (!found && ((vec >> i) & NUM_WAYS'(1)) != '0) begin
                found     = 1'b1;
                first_set = WAYS_W'(i);
            end
        end
    endfunction

    assign req_tag  = req_addr[ADDR_W-1 : S_INDEX+S_OFFSET];
    assign req_set  = req_addr[S_INDEX+S_OFFSET-1 : S_OFFSET];
    assign wr_tag   = wr_addr[ADDR_W-1 : S_INDEX+S_OFFSET];
    assign wr_set   = wr_addr[S_INDEX+S_OFFSET-1 : S_OFFSET];
    assign walk_set = walk_cnt[S_INDEX-1:0];

    assign unused_offset_bits = ^{req_addr[S_OFFSET-1:0], wr_addr[S_OFFSET-1:0]};

    assign busy   = (state == ST_WALK);
    assign req_go = req_valid && !busy;
    assign wr_go  = wr_en && !busy;

    // Walker state register; reset restarts the clear at set 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_WALK;
            walk_cnt <= '0;
        end else begin
            state    <= state_nx;
            walk_cnt <= walk_cnt_nx;
        end
    end

    // Walker next state: one set per cycle, flush accepted only when idle.
    always_comb begin
        state_nx    = state;
        walk_cnt_nx = walk_cnt;
        unique case (state)
            ST_IDLE: begin
                if (flush_req) begin
                    state_nx    = ST_WALK;
                    walk_cnt_nx = '0;
                end
            end
            ST_WALK: begin
                walk_cnt_nx = walk_cnt + CNT_ONE;
                if (walk_cnt == LAST_SET) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        assign hit_vec[w] = valid_mem[req_set][w] && (tag_mem[req_set][w] == req_tag);
    end

    assign inv_vec    = ~valid_mem[req_set];
    assign lk_hit     = |hit_vec;
    assign hit_way    = first_set(hit_vec);
    assign victim_way = (|inv_vec) ? first_set(inv_vec) : plru_victim;
    assign lk_way     = lk_hit ? hit_way : victim_way;
    assign lk_tree    = plru_mem[req_set];

    // Hit touch first; a write touch to the same set chains on its result.
    assign wr_base_tree = (req_go && lk_hit && (req_set == wr_set)) ? hit_tree : plru_mem[wr_set];

    cache_plru #(.NUM_WAYS(NUM_WAYS)) u_plru_hit (
        .tree      (lk_tree),
        .touch_way (hit_way),
        .victim    (plru_victim),
        .next_tree (hit_tree)
    );

    cache_plru #(.NUM_WAYS(NUM_WAYS)) u_plru_wr (
        .tree      (wr_base_tree),
        .touch_way (wr_way),
        .victim    (unused_wr_victim),
        .next_tree (wr_tree)
    );

    assign wr_old = data_mem[wr_set][wr_way];
    for (genvar b = 0; b < MASK_W; b++) begin : g_byte
        assign wr_merged[8*b +: 8] = wr_byte_en[b] ? wr_line[8*b +: 8] : wr_old[8*b +: 8];
    end

    // Data and tag writes at the edge; lookups on the same edge see old contents.
    always_ff @(posedge clk) begin
        if (wr_go) begin
            data_mem[wr_set][wr_way] <= wr_merged;
            if (wr_tag_en) begin
                tag_mem[wr_set][wr_way] <= wr_tag;
            end
        end
    end

    // Valid/dirty/PLRU: walker clears while busy, otherwise hit touch then write updates.
    always_ff @(posedge clk) begin
        if (busy) begin
            valid_mem[walk_set] <= '0;
            dirty_mem[walk_set] <= '0;
            plru_mem[walk_set]  <= '0;
        end else begin
            if (req_go && lk_hit) begin
                plru_mem[req_set] <= hit_tree;
            end
            if (wr_go) begin
                if (wr_tag_en) begin
                    valid_mem[wr_set][wr_way] <= 1'b1;
                end
                if (wr_dirty_set) begin
                    dirty_mem[wr_set][wr_way] <= 1'b1;
                end else if (wr_dirty_clr) begin
                    dirty_mem[wr_set][wr_way] <= 1'b0;
                end
                if (wr_touch) begin
                    plru_mem[wr_set] <= wr_tree;
                end
            end
        end
    end

    // Registered lookup response; fields hold between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid        <= 1'b0;
            rsp_hit          <= 1'b0;
            rsp_way          <= '0;
            rsp_line         <= '0;
            rsp_victim_valid <= 1'b0;
            rsp_victim_dirty <= 1'b0;
            rsp_victim_tag   <= '0;
        end else begin
            rsp_valid <= req_go;
            if (req_go) begin
                rsp_hit          <= lk_hit;
                rsp_way          <= lk_way;
                rsp_line         <= data_mem[req_set][lk_way];
                rsp_victim_valid <= valid_mem[req_set][victim_way];
                rsp_victim_dirty <= dirty_mem[req_set][victim_way];
                rsp_victim_tag   <= tag_mem[req_set][victim_way];
            end
        end
    end

endmodule
